ahb_region_decoder: RTL and testbench

Registered, parametrised AHB-Lite address-phase decoder for the slave register file. It captures each accepted address phase, maps address and size onto a region code plus byte-lane enables, and drives the data-phase read/write strobes. Illegal accesses (unmapped, write to read-only, oversize, misaligned) get the two-cycle AHB ERROR response. It sits between the bus interface and the register/FIFO storage and replaces the purely combinational decoder.

---
 rtl/ahb_region_decoder.sv | 194 +++++++++++++++++++
 tb/tb_ahb_region_decoder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_region_decoder.sv
// ahb_region_decoder
// Registered AHB-Lite address-phase decoder for the slave register file.
// Captures each accepted address phase, maps address/size onto a region
// code and byte-lane enables, and drives data-phase read/write strobes.
// Illegal accesses receive the two-cycle AHB ERROR response.
//
// Optional feature macro: AHB_REGION_DECODER_ALIGN_CHECK_EN
//   defined   : misaligned accesses are errors
//   undefined : low address bits are forced to zero and the access proceeds
module ahb_region_decoder #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 4,
   parameter int unsigned BUF_BYTES   = 4,
   parameter int unsigned STATUS_ADDR = 4,
   parameter int unsigned ERROR_ADDR  = 6,
   parameter int unsigned OCC_ADDR    = 8,
   parameter int unsigned TXC_ADDR    = 12,
   parameter int unsigned FLUSH_ADDR  = 13
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  hsel,
   input  logic [ADDR_W-1:0]     haddr,
   input  logic [1:0]            htrans,
   input  logic [2:0]            hsize,
   input  logic                  hwrite,
   input  logic                  hready,
   output logic                  hready_out,
   output logic                  hresp,
   output logic [3:0]            value_location,
   output logic [DATA_W/8-1:0]   byte_en,
   output logic                  rd_en,
   output logic                  wr_en,
   output logic                  access_err
);

   localparam int unsigned LANE_W = DATA_W / 8;
   localparam int unsigned LSB_W  = $clog2(LANE_W);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_OK   = 2'd1;
   localparam logic [1:0] S_ERR1 = 2'd2;
   localparam logic [1:0] S_ERR2 = 2'd3;

   localparam logic [3:0] LOC_BUFFER       = 4'd0;
   localparam logic [3:0] LOC_STATUS       = 4'd4;
   localparam logic [3:0] LOC_STATUS_LOWER = 4'd5;
   localparam logic [3:0] LOC_STATUS_UPPER = 4'd6;
   localparam logic [3:0] LOC_ERROR        = 4'd7;
   localparam logic [3:0] LOC_ERROR_LOWER  = 4'd8;
   localparam logic [3:0] LOC_ERROR_UPPER  = 4'd9;
   localparam logic [3:0] LOC_TX_CONTROL   = 4'd10;
   localparam logic [3:0] LOC_FLUSH_BUFFER = 4'd11;
   localparam logic [3:0] LOC_BUFFER_OCCUP = 4'd12;
   localparam logic [3:0] LOC_NONE         = 4'd15;

   logic [1:0]        state_q, state_d;
   logic              hready_out_q, hready_out_d;
   logic              hresp_q, hresp_d;
   logic [3:0]        value_location_q, value_location_d;
   logic [LANE_W-1:0] byte_en_q, byte_en_d;
   logic              rd_en_q, rd_en_d;
   logic              wr_en_q, wr_en_d;
   logic              access_err_q, access_err_d;

   logic              accept;
   logic              dec_ok;
   logic              misaligned;
   logic [3:0]        dec_loc;
   logic [LANE_W-1:0] dec_be;
   int unsigned       addr;
   int unsigned       nbytes;
   logic              htrans_seq_unused;

   // SEQ vs NONSEQ makes no difference to the decode
   assign htrans_seq_unused = htrans[0];
   assign accept = hsel & hready & htrans[1];

   // Address-phase decode: legality, region code and byte lanes
   always_comb begin
      nbytes = 32'd1 << hsize;
      addr   = 32'(haddr);
`ifdef AHB_REGION_DECODER_ALIGN_CHECK_EN
      misaligned = (addr % nbytes) != 32'd0;
`else
      addr       = addr & ~(nbytes - 32'd1);
      misaligned = 1'b0;
`endif
      dec_ok  = 1'b1;
      dec_loc = LOC_NONE;
      if (32'(hsize) > LSB_W) begin
         dec_ok = 1'b0;
      end else if (misaligned) begin
         dec_ok = 1'b0;
      end else if (addr + nbytes <= BUF_BYTES) begin
         dec_loc = LOC_BUFFER;
      end else if (addr == STATUS_ADDR && nbytes == 32'd2) begin
         dec_loc = LOC_STATUS;
      end else if (addr == STATUS_ADDR && nbytes == 32'd1) begin
         dec_loc = LOC_STATUS_LOWER;
      end else if (addr == STATUS_ADDR + 32'd1 && nbytes == 32'd1) begin
         dec_loc = LOC_STATUS_UPPER;
      end else if (addr == ERROR_ADDR && nbytes == 32'd2) begin
         dec_loc = LOC_ERROR;
      end else if (addr == ERROR_ADDR && nbytes == 32'd1) begin
         dec_loc = LOC_ERROR_LOWER;
      end else if (addr == ERROR_ADDR + 32'd1 && nbytes == 32'd1) begin
         dec_loc = LOC_ERROR_UPPER;
      end else if (addr == OCC_ADDR && nbytes == 32'd1) begin
         dec_loc = LOC_BUFFER_OCCUP;
      end else if (addr == TXC_ADDR && nbytes == 32'd1) begin
         dec_loc = LOC_TX_CONTROL;
      end else if (addr == FLUSH_ADDR && nbytes == 32'd1) begin
         dec_loc = LOC_FLUSH_BUFFER;
      end else begin
         dec_ok = 1'b0;
      end
      // Status, error and occupancy registers are read-only
      if (dec_ok && hwrite &&
          ((dec_loc >= LOC_STATUS && dec_loc <= LOC_ERROR_UPPER) ||
           dec_loc == LOC_BUFFER_OCCUP)) begin
         dec_ok = 1'b0;
      end
      // Lane mask is built in a wide word so the full-width mask never
      // overflows before the shift; the result is truncated to the lanes.
      dec_be = LANE_W'(((32'd1 << nbytes) - 32'd1) << (addr % LANE_W));
   end

   // Next state and next registered outputs
   always_comb begin
      state_d          = S_IDLE;
      hready_out_d     = 1'b1;
      hresp_d          = 1'b0;
      value_location_d = LOC_NONE;
      byte_en_d        = '0;
      rd_en_d          = 1'b0;
      wr_en_d          = 1'b0;
      access_err_d     = 1'b0;
      if (state_q == S_ERR1) begin
         state_d = S_ERR2;
      end else if (accept) begin
         state_d = dec_ok ? S_OK : S_ERR1;
      end
      case (state_d)
         S_OK: begin
            value_location_d = dec_loc;
            byte_en_d        = dec_be;
            rd_en_d          = ~hwrite;
            wr_en_d          = hwrite;
         end
         S_ERR1: begin
            hready_out_d = 1'b0;
            hresp_d      = 1'b1;
            access_err_d = 1'b1;
         end
         S_ERR2: begin
            hresp_d = 1'b1;
         end
         default: ;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= S_IDLE;
         hready_out_q     <= 1'b1;
         hresp_q          <= 1'b0;
         value_location_q <= LOC_NONE;
         byte_en_q        <= '0;
         rd_en_q          <= 1'b0;
         wr_en_q          <= 1'b0;
         access_err_q     <= 1'b0;
      end else begin
         state_q          <= state_d;
         hready_out_q     <= hready_out_d;
         hresp_q          <= hresp_d;
         value_location_q <= value_location_d;
         byte_en_q        <= byte_en_d;
         rd_en_q          <= rd_en_d;
         wr_en_q          <= wr_en_d;
         access_err_q     <= access_err_d;
      end
   end

   assign hready_out     = hready_out_q;
   assign hresp          = hresp_q;
   assign value_location = value_location_q;
   assign byte_en        = byte_en_q;
   assign rd_en          = rd_en_q;
   assign wr_en          = wr_en_q;
   assign access_err     = access_err_q;

endmodule

// File: tb/tb_ahb_region_decoder.sv
// Testbench for ahb_region_decoder (default parameters, DATA_W=32).
// Observed vector layout: {hready_out, hresp, access_err, rd_en, wr_en,
// value_location[3:0], byte_en[3:0]}.
module tb_ahb_region_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       hsel;
   logic [3:0] haddr;
   logic [1:0] htrans;
   logic [2:0] hsize;
   logic       hwrite;
   logic       hready;
   logic       hready_out;
   logic       hresp;
   logic [3:0] value_location;
   logic [3:0] byte_en;
   logic       rd_en;
   logic       wr_en;
   logic       access_err;

   int errors = 0;
   int checks = 0;

   localparam logic [12:0] V_IDLE = {5'b10000, 4'd15, 4'b0000};
   localparam logic [12:0] V_ERR1 = {5'b01100, 4'd15, 4'b0000};
   localparam logic [4:0]  V_ERR2 = 5'b11000;

   typedef struct {
      logic [12:0] v;
      bit          full;
   } exp_t;

   exp_t exp_q[$];

   ahb_region_decoder dut (
      .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
      .hsize(hsize), .hwrite(hwrite), .hready(hready),
      .hready_out(hready_out), .hresp(hresp), .value_location(value_location),
      .byte_en(byte_en), .rd_en(rd_en), .wr_en(wr_en), .access_err(access_err)
   );

   always #5 clk = ~clk;

   function automatic logic [12:0] obs();
      return {hready_out, hresp, access_err, rd_en, wr_en, value_location, byte_en};
   endfunction

   function automatic logic [12:0] ok_v(input bit wr, input int loc, input int be);
      logic [12:0] v;
      v = {1'b1, 1'b0, 1'b0, ~wr, wr, 4'(loc), 4'(be)};
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit sel, input int a, input int sz, input bit wr);
      hsel   = sel;
      haddr  = 4'(a);
      htrans = sel ? 2'b10 : 2'b00;
      hsize  = 3'(sz);
      hwrite = wr;
      hready = 1'b1;
   endtask

   // Register map model: returns legality, region code and lane mask
   function automatic void ref_decode(input int a_in, input int sz, input bit wr,
                                      output bit ok, output int loc, output int be);
      int n, a;
      n   = 1 << sz;
      a   = a_in;
      ok  = 1;
      loc = 15;
      if (sz > 2) ok = 0;
`ifdef AHB_REGION_DECODER_ALIGN_CHECK_EN
      else if (a % n != 0) ok = 0;
`else
      a = a - (a % n);
`endif
      if (ok) begin
         if (a + n <= 4) loc = 0;
         else if (a >= 4 && a <= 7) begin
            int base, code;
            base = (a < 6) ? 4 : 6;
            code = (a < 6) ? 4 : 7;
            if (n == 2 && a == base) loc = code;
            else if (n == 1) loc = code + 1 + (a - base);
            else ok = 0;
         end
         else if (a == 8 && n == 1) loc = 12;
         else if (a == 12 && n == 1) loc = 10;
         else if (a == 13 && n == 1) loc = 11;
         else ok = 0;
         if (ok && wr && ((loc >= 4 && loc <= 9) || loc == 12)) ok = 0;
      end
      if (!ok) loc = 15;
      be = (((1 << n) - 1) << (a % 4)) & 15;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      drive(0, 0, 0, 0);
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (obs() !== V_IDLE) begin
            errors++;
            $display("FAIL reset_idle[%0d]: got %b expected %b", i, obs(), V_IDLE);
         end
      end
   endtask

   task automatic test_buffer_b2b();
      drive(1, 0, 2, 0);
      tick();
      checks++;
      if (obs() !== ok_v(0, 0, 4'b1111)) begin
         errors++;
         $display("FAIL word_read_0: got %b expected %b", obs(), ok_v(0, 0, 4'b1111));
      end
      drive(1, 2, 1, 1);
      tick();
      checks++;
      if (obs() !== ok_v(1, 0, 4'b1100)) begin
         errors++;
         $display("FAIL half_write_2: got %b expected %b", obs(), ok_v(1, 0, 4'b1100));
      end
      drive(0, 0, 0, 0);
      tick();
      checks++;
      if (obs() !== V_IDLE) begin
         errors++;
         $display("FAIL after_b2b_idle: got %b expected %b", obs(), V_IDLE);
      end
   endtask

   task automatic test_regs();
      drive(1, 5, 0, 0);
      tick();
      checks++;
      if (obs() !== ok_v(0, 6, 4'b0010)) begin
         errors++;
         $display("FAIL status_upper: got %b expected %b", obs(), ok_v(0, 6, 4'b0010));
      end
      drive(1, 6, 1, 0);
      tick();
      checks++;
      if (obs() !== ok_v(0, 7, 4'b1100)) begin
         errors++;
         $display("FAIL error_half: got %b expected %b", obs(), ok_v(0, 7, 4'b1100));
      end
      drive(1, 12, 0, 1);
      tick();
      checks++;
      if (obs() !== ok_v(1, 10, 4'b0001)) begin
         errors++;
         $display("FAIL txc_write: got %b expected %b", obs(), ok_v(1, 10, 4'b0001));
      end
      drive(0, 0, 0, 0);
      tick();
   endtask

   task automatic test_err_b2b();
      drive(1, 4, 1, 1);
      tick();
      checks++;
      if (obs() !== V_ERR1) begin
         errors++;
         $display("FAIL ro_write_err1: got %b expected %b", obs(), V_ERR1);
      end
      // an accept attempted during ERR1 must be ignored
      drive(1, 0, 2, 0);
      tick();
      checks++;
      if (obs() !== V_ERR1 && obs()[12:8] !== V_ERR2) begin
         errors++;
         $display("FAIL ro_write_err2: got %b expected %b", obs()[12:8], V_ERR2);
      end
      else if (obs()[12:8] !== V_ERR2) begin
         errors++;
         $display("FAIL ro_write_err2: got %b expected %b", obs()[12:8], V_ERR2);
      end
      drive(1, 0, 2, 0);
      tick();
      checks++;
      if (obs() !== ok_v(0, 0, 4'b1111)) begin
         errors++;
         $display("FAIL read_after_err2: got %b expected %b", obs(), ok_v(0, 0, 4'b1111));
      end
      drive(0, 0, 0, 0);
      tick();
      checks++;
      if (obs() !== V_IDLE) begin
         errors++;
         $display("FAIL err_seq_idle: got %b expected %b", obs(), V_IDLE);
      end
   endtask

   task automatic test_misalign();
      drive(1, 1, 1, 0);
      tick();
      drive(0, 0, 0, 0);
`ifdef AHB_REGION_DECODER_ALIGN_CHECK_EN
      checks++;
      if (obs() !== V_ERR1) begin
         errors++;
         $display("FAIL misalign_err1: got %b expected %b", obs(), V_ERR1);
      end
      tick();
      checks++;
      if (obs()[12:8] !== V_ERR2) begin
         errors++;
         $display("FAIL misalign_err2: got %b expected %b", obs()[12:8], V_ERR2);
      end
`else
      checks++;
      if (obs() !== ok_v(0, 0, 4'b0011)) begin
         errors++;
         $display("FAIL misalign_forced: got %b expected %b", obs(), ok_v(0, 0, 4'b0011));
      end
`endif
      tick();
      checks++;
      if (obs() !== V_IDLE) begin
         errors++;
         $display("FAIL misalign_idle: got %b expected %b", obs(), V_IDLE);
      end
   endtask

   task automatic test_rst_in_err1();
      drive(1, 15, 0, 0);
      tick();
      checks++;
      if (obs() !== V_ERR1) begin
         errors++;
         $display("FAIL unmapped_err1: got %b expected %b", obs(), V_ERR1);
      end
      rst = 1'b1;
      drive(0, 0, 0, 0);
      tick();
      checks++;
      if (obs() !== V_IDLE) begin
         errors++;
         $display("FAIL rst_in_err1: got %b expected %b", obs(), V_IDLE);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (obs() !== V_IDLE) begin
         errors++;
         $display("FAIL no_err2_after_rst: got %b expected %b", obs(), V_IDLE);
      end
   endtask

   task automatic test_random();
      exp_t cur, e;
      bit   ok;
      int   loc, be, a, sz;
      bit   wr;
      cur.v    = V_IDLE;
      cur.full = 1;
      exp_q.delete();
      for (int n = 0; n < 400; n++) begin
         a      = int'($urandom_range(0, 15));
         sz     = int'($urandom_range(0, 3));
         wr     = 1'($urandom_range(0, 1));
         hsel   = ($urandom_range(0, 3) != 0);
         haddr  = 4'(a);
         htrans = 2'($urandom_range(0, 3));
         hsize  = 3'(sz);
         hwrite = wr;
         hready = ($urandom_range(0, 7) != 0);
         if (hsel && hready && htrans[1] && cur.v[12]) begin
            ref_decode(a, sz, wr, ok, loc, be);
            if (ok) begin
               e.v = ok_v(wr, loc, be);
               e.full = 1;
               exp_q.push_back(e);
            end else begin
               e.v = V_ERR1;
               e.full = 1;
               exp_q.push_back(e);
               e.v = {V_ERR2, 8'h00};
               e.full = 0;
               exp_q.push_back(e);
            end
         end
         tick();
         if (exp_q.size() != 0) cur = exp_q.pop_front();
         else begin
            cur.v = V_IDLE;
            cur.full = 1;
         end
         checks++;
         if (cur.full ? (obs() !== cur.v) : (obs()[12:8] !== cur.v[12:8])) begin
            errors++;
            $display("FAIL random[%0d] a=%0d sz=%0d wr=%0d: got %b expected %b",
                     n, a, sz, wr, obs(), cur.v);
         end
      end
      drive(0, 0, 0, 0);
      tick();
      tick();
   endtask

   initial begin
      drive(0, 0, 0, 0);
      rst = 1'b1;
      test_reset();
      test_buffer_b2b();
      test_regs();
      test_err_b2b();
      test_misalign();
      test_rst_in_err1();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
